// File: rtl/aes_block_tx_if.sv
// ---------------------------------------------------------------------------
// aes_block_tx_if
// Block handshake between the AES core (master) and the byte streamer
// (slave, aes_block_tx).
//   blk_valid  master -> slave  blk_data holds a complete AES output block
//   blk_ready  slave  -> master streamer can accept a block this cycle
//   blk_data   master -> slave  AES output block, 8*BLOCK_BYTES bits
// A block transfers on a clock edge where blk_valid & blk_ready.
// ---------------------------------------------------------------------------
interface aes_block_tx_if #(
  parameter int BLOCK_BYTES = 16
) ();
  logic                     blk_valid;
  logic                     blk_ready;
  logic [8*BLOCK_BYTES-1:0] blk_data;

  modport master (output blk_valid, output blk_data, input blk_ready);
  modport slave  (input blk_valid, input blk_data, output blk_ready);
endinterface

// File: rtl/aes_block_tx.sv
// ---------------------------------------------------------------------------
// aes_block_tx
// Latches one AES result block and streams it byte by byte into the UART TX
// FIFO, MSB byte first, stalling while the FIFO reports full.
//
// Parameters
//   BLOCK_BYTES  bytes per block
//   BYTE_GAP     idle cycles inserted after each FIFO write (0 = back-to-back)
// Ports
//   clk_100MHz  system clock, rising edge
//   reset_n     synchronous active-low reset
//   blk         block handshake (slave side): blk_valid/blk_ready/blk_data
//   flush       synchronous abort of the block in progress
//   tx_full     UART TX FIFO full
//   tx_wr       FIFO write strobe, one byte per high cycle
//   tx_data     byte presented with tx_wr
//   busy        a block is held and not yet fully sent
//   done        one-cycle pulse after the final write of a block
// Configuration
//   HEX_ASCII_EN  when defined, each byte is sent as two uppercase ASCII hex
//                 characters (high nibble first), followed by CR LF.
// ---------------------------------------------------------------------------
module aes_block_tx #(
  parameter int BLOCK_BYTES = 16,
  parameter int BYTE_GAP    = 0
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  aes_block_tx_if.slave        blk,
  input  logic                 flush,
  input  logic                 tx_full,
  output logic                 tx_wr,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 done
);

  localparam int W = 8 * BLOCK_BYTES;
`ifdef HEX_ASCII_EN
  localparam int N_WR = 2 * BLOCK_BYTES + 2;
`else
  localparam int N_WR = BLOCK_BYTES;
`endif
  localparam int CNT_W = $clog2(N_WR + 1);
  localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(N_WR - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic [7:0] wr_byte;   // character/byte presented in SEND
  logic       shift_now; // this write consumes the top byte of shreg

`ifdef HEX_ASCII_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 'A' - 10 = 8'h37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    if (cnt_q == CNT_W'(2 * BLOCK_BYTES))
      wr_byte = 8'h0D;
    else if (cnt_q == CNT_W'(2 * BLOCK_BYTES + 1))
      wr_byte = 8'h0A;
    else if (cnt_q[0])
      wr_byte = hex_char(shreg_q[W-5 -: 4]);
    else
      wr_byte = hex_char(shreg_q[W-1 -: 4]);
    // Shift once per byte, after its low-nibble character.
    shift_now = cnt_q[0] && (cnt_q < CNT_W'(2 * BLOCK_BYTES));
  end
`else
  always_comb begin
    wr_byte   = shreg_q[W-1 -: 8];
    shift_now = 1'b1;
  end
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    tx_wr         = 1'b0;
    tx_data       = 8'h00;
    busy          = 1'b1;
    done          = 1'b0;
    blk.blk_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy          = 1'b0;
        blk.blk_ready = 1'b1;
        if (blk.blk_valid) begin
          shreg_d = blk.blk_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_data = wr_byte;
        tx_wr   = ~tx_full;
        if (!tx_full) begin
          cnt_d = cnt_q + 1'b1;
          if (shift_now) shreg_d = shreg_q << 8;
          if (cnt_q == LAST_WR) begin
            state_d = DONE;
          end else if (BYTE_GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = SEND;
        else             gap_d   = gap_q - 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any transition above, including an accept in IDLE.
    if (flush) begin
      state_d = IDLE;
      shreg_d = shreg_q;
      cnt_d   = '0;
      gap_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_aes_block_tx.sv
// ---------------------------------------------------------------------------
// tb_aes_block_tx
// Two instances: dut0 (BYTE_GAP=0) for stream/stall/back-to-back/abort/reset,
// dut1 (BYTE_GAP=2) for gap spacing. Expected bytes are pushed to a per-
// instance queue when a block is accepted and popped by a negedge monitor on
// every tx_wr. Expansion follows HEX_ASCII_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_aes_block_tx;

`ifdef HEX_ASCII_EN
  localparam int NWR = 34;
`else
  localparam int NWR = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       flush0, flush1, tx_full0, tx_full1;
  logic       tx_wr0, tx_wr1, busy0, busy1, done0, done1;
  logic [7:0] tx_data0, tx_data1;

  aes_block_tx_if #(.BLOCK_BYTES(16)) bi0 ();
  aes_block_tx_if #(.BLOCK_BYTES(16)) bi1 ();

  aes_block_tx #(.BLOCK_BYTES(16), .BYTE_GAP(0)) dut0 (
    .clk_100MHz(clk), .reset_n(reset_n), .blk(bi0), .flush(flush0),
    .tx_full(tx_full0), .tx_wr(tx_wr0), .tx_data(tx_data0),
    .busy(busy0), .done(done0)
  );

  aes_block_tx #(.BLOCK_BYTES(16), .BYTE_GAP(2)) dut1 (
    .clk_100MHz(clk), .reset_n(reset_n), .blk(bi1), .flush(flush1),
    .tx_full(tx_full1), .tx_wr(tx_wr1), .tx_data(tx_data1),
    .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int wr_cnt0 = 0, wr_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0, since1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_ref(input logic [3:0] n);
    string s = "0123456789ABCDEF";
    return s[n];
  endfunction

  function automatic void push_exp(input int inst, input logic [127:0] d);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = d[127-8*i -: 8];
`ifdef HEX_ASCII_EN
      if (inst == 0) begin exp_q0.push_back(hex_ref(b[7:4])); exp_q0.push_back(hex_ref(b[3:0])); end
      else           begin exp_q1.push_back(hex_ref(b[7:4])); exp_q1.push_back(hex_ref(b[3:0])); end
`else
      if (inst == 0) exp_q0.push_back(b);
      else           exp_q1.push_back(b);
`endif
    end
`ifdef HEX_ASCII_EN
    if (inst == 0) begin exp_q0.push_back(8'h0D); exp_q0.push_back(8'h0A); end
    else           begin exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A); end
`endif
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_wr0 === 1'b1) begin
      wr_cnt0++;
      check("wr0_expected", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) check("byte0", tx_data0, exp_q0.pop_front());
    end
    if (tx_full0 === 1'b1) check("wr0_while_full", tx_wr0, 0);
    if (done0 === 1'b1) done_cnt0++;

    if (tx_wr1 === 1'b1) begin
      wr_cnt1++;
      check("wr1_expected", exp_q1.size() != 0, 1);
      if (exp_q1.size() % NWR != 0) check("gap1", since1, 2);
      if (exp_q1.size() != 0) check("byte1", tx_data1, exp_q1.pop_front());
      since1 = 0;
    end else begin
      since1++;
    end
    if (done1 === 1'b1) done_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int inst, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((inst == 0) ? done0 : done1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_ready"}, bi0.blk_ready, 1);
    check({tag, "_wr"},    tx_wr0,        0);
    check({tag, "_data"},  tx_data0,      0);
    check({tag, "_busy"},  busy0,         0);
    check({tag, "_done"},  done0,         0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w1;
    logic [127:0] blk_a;

    reset_n = 1'b0; flush0 = 1'b0; flush1 = 1'b0; tx_full0 = 1'b0; tx_full1 = 1'b0;
    bi0.blk_valid = 1'b0; bi0.blk_data = '0;
    bi1.blk_valid = 1'b0; bi1.blk_data = '0;
    repeat (3) tick();
    check_reset0("rst");
    reset_n = 1'b1;
    tick();

    // 1: raw stream, latency 1, consecutive writes, single done pulse
    blk_a = 128'h000102030405060708090A0B0C0D0E0F;
    d0 = done_cnt0;
    bi0.blk_valid = 1'b1; bi0.blk_data = blk_a;
    check("t1_ready", bi0.blk_ready, 1);
    push_exp(0, blk_a);
    tick();
    bi0.blk_valid = 1'b0; bi0.blk_data = '1;   // must not affect held block
    for (int i = 0; i < NWR; i++) begin
      check("t1_wr", tx_wr0, 1);
      check("t1_busy", busy0, 1);
      tick();
    end
    check("t1_done", done0, 1);
    check("t1_wr_off", tx_wr0, 0);
    check("t1_ready_low", bi0.blk_ready, 0);
    tick();
    check("t1_done_off", done0, 0);
    check("t1_idle_ready", bi0.blk_ready, 1);
    check("t1_q_empty", exp_q0.size(), 0);
    check("t1_done_cnt", done_cnt0 - d0, 1);

    // 2: stall for 4 cycles after 5 writes; byte held, nothing lost
    d0 = done_cnt0;
    bi0.blk_valid = 1'b1; bi0.blk_data = blk_a;
    push_exp(0, blk_a);
    tick();
    bi0.blk_valid = 1'b0;
    repeat (5) tick();
    tx_full0 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_wr_held", tx_wr0, 0);
      check("t2_data_held", tx_data0, exp_q0[0]);
      tick();
    end
    tx_full0 = 1'b0;
    wait_done(0, NWR + 5);
    tick();
    check("t2_q_empty", exp_q0.size(), 0);
    check("t2_done_cnt", done_cnt0 - d0, 1);

    // 3: BYTE_GAP=2 on dut1; monitor checks 2 idle cycles between writes
    w1 = wr_cnt1;
    bi1.blk_valid = 1'b1; bi1.blk_data = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    push_exp(1, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F);
    tick();
    bi1.blk_valid = 1'b0;
    wait_done(1, 3 * NWR + 5);
    check("t3_wr_count", wr_cnt1 - w1, NWR);
    tick();
    check("t3_q_empty", exp_q1.size(), 0);
    check("t3_done_cnt", done_cnt1, 1);

    // 4: back-to-back with blk_valid held high
    d0 = done_cnt0;
    bi0.blk_valid = 1'b1; bi0.blk_data = 128'h112233445566778899AABBCCDDEEFF00;
    push_exp(0, 128'h112233445566778899AABBCCDDEEFF00);
    tick();
    bi0.blk_data = 128'hFEDCBA98765432100123456789ABCDEF;
    for (int i = 0; i < NWR + 1; i++) begin
      check("t4_ready_low", bi0.blk_ready, 0);
      tick();
    end
    check("t4_ready_idle", bi0.blk_ready, 1);
    push_exp(0, 128'hFEDCBA98765432100123456789ABCDEF);
    tick();
    bi0.blk_valid = 1'b0;
    wait_done(0, NWR + 5);
    tick();
    check("t4_q_empty", exp_q0.size(), 0);
    check("t4_done_cnt", done_cnt0 - d0, 2);

    // 5a: flush with blk_valid in IDLE -> not accepted
    bi0.blk_valid = 1'b1; flush0 = 1'b1;
    tick();
    bi0.blk_valid = 1'b0; flush0 = 1'b0;
    #1;
    check("t5_no_accept_busy", busy0, 0);
    check("t5_no_accept_wr", tx_wr0, 0);

    // 5b: flush at the edge that writes byte 3
    d0 = done_cnt0;
    bi0.blk_valid = 1'b1; bi0.blk_data = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    push_exp(0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    tick();
    bi0.blk_valid = 1'b0;
    repeat (3) tick();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    check("t5_flush_wr", tx_wr0, 0);
    check("t5_flush_done", done0, 0);
    check("t5_flush_ready", bi0.blk_ready, 1);
    check("t5_flush_busy", busy0, 0);
    check("t5_left", exp_q0.size(), NWR - 4);
    exp_q0.delete();
    repeat (3) tick();
    check("t5_flush_no_done", done_cnt0 - d0, 0);

    // 5c: reset mid-block, asserted together with flush
    bi0.blk_valid = 1'b1; bi0.blk_data = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
    push_exp(0, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A);
    tick();
    bi0.blk_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0; flush0 = 1'b1;
    tick();
    check_reset0("t5_rst");
    reset_n = 1'b1; flush0 = 1'b0;
    exp_q0.delete();
    repeat (2) tick();
    check("t5_rst_no_done", done_cnt0 - d0, 0);

    // 6: AB00..00 block (hex: 'A','B', 30 x '0', CR, LF)
    d0 = done_cnt0;
    bi0.blk_valid = 1'b1; bi0.blk_data = 128'hAB000000000000000000000000000000;
    push_exp(0, 128'hAB000000000000000000000000000000);
    tick();
    bi0.blk_valid = 1'b0;
    wait_done(0, NWR + 5);
    tick();
    check("t6_q_empty", exp_q0.size(), 0);
    check("t6_done_cnt", done_cnt0 - d0, 1);
    check("t6_q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
